// File: rtl/aes_encrypt_iter_pkg.sv
// Shared definitions for the iterative AES-128 encryption core.
//   AES_NR    : number of AES-128 rounds
//   BLK_W     : block width in bits
//   RK_W      : width of the full round-key bus (NR+1 keys of 128 bits)
//   fsm_e     : 2-bit controller state encoding
//   sbox()    : forward S-box lookup
//   xtime()   : multiply by x in GF(2^8), polynomial x^8+x^4+x^3+x+1
//   rk_slice(): pick round key i out of the round-key bus
package aes_encrypt_iter_pkg;

  localparam int AES_NR = 10;
  localparam int BLK_W  = 128;
  localparam int RK_W   = BLK_W * (AES_NR + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_e;

  // Entry 0 occupies the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Indices past the last round key return zero so the lookup never
  // reaches outside the bus (the round counter parks at NR+1 in DONE).
  function automatic logic [BLK_W-1:0] rk_slice(input logic [RK_W-1:0] rks,
                                                input logic [3:0]      idx);
    if (int'(idx) > AES_NR) return '0;
    return rks[BLK_W*int'(idx) +: BLK_W];
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// Handshake and key bus between the key-expansion top, the data producer,
// the data consumer and the AES encryption core.
//   key_ready/round_keys : from key expansion
//   pt_valid/pt_ready/plaintext   : plaintext handshake
//   ct_valid/ct_ready/ciphertext  : ciphertext handshake
//   busy/abort                    : core status
// master = environment side, slave = encryption core.
interface aes_encrypt_iter_if;
  import aes_encrypt_iter_pkg::*;

  logic              key_ready;
  logic [RK_W-1:0]   round_keys;
  logic              pt_valid;
  logic              pt_ready;
  logic [BLK_W-1:0]  plaintext;
  logic              ct_valid;
  logic              ct_ready;
  logic [BLK_W-1:0]  ciphertext;
  logic              busy;
  logic              abort;

  modport master (
    output key_ready, round_keys, pt_valid, plaintext, ct_ready,
    input  pt_ready, ct_valid, ciphertext, busy, abort
  );

  modport slave (
    input  key_ready, round_keys, pt_valid, plaintext, ct_ready,
    output pt_ready, ct_valid, ciphertext, busy, abort
  );

endinterface

// File: rtl/aes_round.sv
// One AES encryption round, purely combinational.
//   state_in    : 128-bit state, byte 0 at [127:120], column-major
//   rkey        : round key added at the end of the round
//   final_round : skip MixColumns (last round)
//   state_out   : resulting state
module aes_round
  import aes_encrypt_iter_pkg::*;
(
  input  logic [BLK_W-1:0] state_in,
  input  logic [BLK_W-1:0] rkey,
  input  logic             final_round,
  output logic [BLK_W-1:0] state_out
);

  logic [7:0] w_sub [16];
  logic [7:0] w_shr [16];
  logic [7:0] w_mix [16];

  // Byte index k = 4*col + row.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      w_sub[k] = sbox(state_in[127 - 8*k -: 8]);
    end
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_shr[4*c + r] = w_sub[4*((c + r) % 4) + r];
      end
    end
    // Each output byte = 2*a[r] ^ 3*a[r+1] ^ a[r+2] ^ a[r+3].
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_mix[4*c + r] = xtime(w_shr[4*c + r])
                       ^ xtime(w_shr[4*c + (r+1)%4]) ^ w_shr[4*c + (r+1)%4]
                       ^ w_shr[4*c + (r+2)%4]
                       ^ w_shr[4*c + (r+3)%4];
      end
    end
    state_out = '0;
    for (int k = 0; k < 16; k++) begin
      state_out[127 - 8*k -: 8] = (final_round ? w_shr[k] : w_mix[k])
                                ^ rkey[127 - 8*k -: 8];
    end
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption core, one round per clock.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : slave side of aes_encrypt_iter_if (round keys, plaintext and
//          ciphertext handshakes, busy/abort status)
// Round keys are read from the shared bus every cycle; dropping key_ready
// mid-encryption aborts the operation with a one-cycle abort pulse.
module aes_encrypt_iter
  import aes_encrypt_iter_pkg::*;
#(
  parameter int NR     = AES_NR,
  parameter int DATA_W = BLK_W
) (
  input  logic              clk,
  input  logic              rst,
  aes_encrypt_iter_if.slave bus
);

  fsm_e              r_fsm,   w_fsm_n;
  logic [3:0]        r_round, w_round_n;
  logic [DATA_W-1:0] r_state, w_state_n;
  logic [DATA_W-1:0] r_ct,    w_ct_n;
  logic              r_abort, w_abort_n;

  logic [DATA_W-1:0] w_rkey0;
  logic [DATA_W-1:0] w_rkey;
  logic [DATA_W-1:0] w_round_out;
  logic              w_final;

  assign w_rkey0 = rk_slice(bus.round_keys, 4'd0);
  assign w_rkey  = rk_slice(bus.round_keys, r_round);
  assign w_final = (r_round == 4'(NR));

  aes_round u_round (
    .state_in    (r_state),
    .rkey        (w_rkey),
    .final_round (w_final),
    .state_out   (w_round_out)
  );

  // pt_ready is forced low while reset is held so nothing upstream sees a
  // ready core before the registers have settled.
  assign bus.pt_ready   = rst && (r_fsm == S_IDLE) && bus.key_ready;
  assign bus.ct_valid   = (r_fsm == S_DONE);
  assign bus.busy       = (r_fsm != S_IDLE);
  assign bus.abort      = r_abort;
  assign bus.ciphertext = r_ct;

  always_comb begin
    w_fsm_n   = r_fsm;
    w_round_n = r_round;
    w_state_n = r_state;
    w_ct_n    = r_ct;
    w_abort_n = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (bus.pt_valid && bus.key_ready) begin
          w_state_n = bus.plaintext ^ w_rkey0;
          w_round_n = 4'd1;
          w_fsm_n   = S_ROUND;
        end
      end
      S_ROUND: begin
        // Keys vanished under us: the partial state is meaningless.
        if (!bus.key_ready) begin
          w_fsm_n   = S_IDLE;
          w_round_n = '0;
          w_abort_n = 1'b1;
        end else begin
          w_state_n = w_round_out;
          w_round_n = r_round + 4'd1;
          if (w_final) begin
            w_ct_n  = w_round_out;
            w_fsm_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Ciphertext is already registered, so key_ready is irrelevant here.
        if (bus.ct_ready) begin
          w_fsm_n   = S_IDLE;
          w_round_n = '0;
        end
      end
      default: begin
        w_fsm_n   = S_IDLE;
        w_round_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fsm   <= S_IDLE;
      r_round <= '0;
      r_state <= '0;
      r_ct    <= '0;
      r_abort <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_n;
      r_round <= w_round_n;
      r_state <= w_state_n;
      r_ct    <= w_ct_n;
      r_abort <= w_abort_n;
    end
  end

endmodule
